// File: rtl/mem_arbiter.sv
// Memory-side responder for the cache line-fill protocol: round-robin arbitration
// between I-cache reads and D-cache reads/writes over an internal line array.
module mem_arbiter #(
   parameter int cache_line_width = 256,
   parameter int addr_width       = 16,
   parameter int line_offset_bits = 4,
   parameter int mem_lines        = 64,
   parameter int mem_latency      = 5
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        petitionICacheArb,
   input  logic [addr_width-1:0]       addrICacheArb,
   output logic                        serviceReadyArbICache,
   output logic [cache_line_width-1:0] dataMemICache,
   input  logic                        petitionDCacheArb,
   input  logic                        writeDCacheArb,
   input  logic [addr_width-1:0]       addrDCacheArb,
   input  logic [cache_line_width-1:0] dataDCacheArb,
   output logic                        serviceReadyArbDCache,
   output logic [cache_line_width-1:0] dataMemDCache
);

   localparam int IDX_W = $clog2(mem_lines);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [1:0] S_TURN = 2'd3;
   // BUSY spans mem_latency-1 edges; ready rises on the edge leaving RESP.
   localparam logic [3:0] CNT_LOAD = 4'(mem_latency - 2);

   logic [1:0]                  r_state;
   logic [3:0]                  r_cnt;
   logic                        r_last_d;
   logic                        r_gnt_d;
   logic                        r_wr;
   logic [IDX_W-1:0]            r_idx;
   logic [cache_line_width-1:0] r_wdata;
   logic                        r_rdy_i;
   logic                        r_rdy_d;
   logic [cache_line_width-1:0] r_data_i;
   logic [cache_line_width-1:0] r_data_d;
   logic [cache_line_width-1:0] r_mem [mem_lines];

   logic [IDX_W-1:0]            w_idx_i;
   logic [IDX_W-1:0]            w_idx_d;
   logic                        w_grant;
   logic                        w_pick_d;
   logic [cache_line_width-1:0] w_resp_line;
   logic                        w_unused;

   assign w_idx_i  = addrICacheArb[line_offset_bits+IDX_W-1:line_offset_bits];
   assign w_idx_d  = addrDCacheArb[line_offset_bits+IDX_W-1:line_offset_bits];
   assign w_unused = ^{addrICacheArb, addrDCacheArb};

   // Round-robin pick: on a conflict the side that did not win last time is served.
   always_comb begin
      w_grant  = petitionICacheArb | petitionDCacheArb;
      w_pick_d = petitionDCacheArb & (~petitionICacheArb | ~r_last_d);
      if (r_wr) begin
         w_resp_line = r_wdata;
      end else begin
         w_resp_line = r_mem[r_idx];
      end
   end

   // Control FSM, request latch and registered response outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= 4'd0;
         r_last_d <= 1'b0;
         r_gnt_d  <= 1'b0;
         r_wr     <= 1'b0;
         r_idx    <= '0;
         r_wdata  <= '0;
         r_rdy_i  <= 1'b0;
         r_rdy_d  <= 1'b0;
         r_data_i <= '0;
         r_data_d <= '0;
      end else begin
         r_rdy_i <= 1'b0;
         r_rdy_d <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant) begin
                  r_gnt_d  <= w_pick_d;
                  r_last_d <= w_pick_d;
                  r_idx    <= w_pick_d ? w_idx_d : w_idx_i;
                  r_wr     <= w_pick_d & writeDCacheArb;
                  if (w_pick_d && writeDCacheArb) begin
                     r_wdata <= dataDCacheArb;
                  end
                  r_cnt    <= CNT_LOAD;
                  r_state  <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (r_cnt == 4'd0) begin
                  r_state <= S_RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_RESP: begin
               if (r_gnt_d) begin
                  r_rdy_d  <= 1'b1;
                  r_data_d <= w_resp_line;
               end else begin
                  r_rdy_i  <= 1'b1;
                  r_data_i <= w_resp_line;
               end
               r_state <= S_TURN;
            end
            S_TURN: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Line array: not reset; a write aborted by reset never lands.
   always_ff @(posedge clk) begin
      if (!reset && (r_state == S_RESP) && r_gnt_d && r_wr) begin
         r_mem[r_idx] <= r_wdata;
      end
   end

   assign serviceReadyArbICache = r_rdy_i;
   assign serviceReadyArbDCache = r_rdy_d;
   assign dataMemICache         = r_data_i;
   assign dataMemDCache         = r_data_d;

endmodule
